// File: rtl/cpu_pkg.sv
// Shared CPU types and widths.
// Fetch-entry bundle carried from fetch to decode.
package cpu_pkg;

  localparam int ADDR_W = 15;
  localparam int INST_W = 16;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small flushable FIFO of fetched instructions.
// Power-of-two depth, so pointers wrap naturally.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; count gates validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues I-mem reads, drives next PC,
// buffers returned words for decode.
module instruction_fetch #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_enable,
  output logic [ADDR_W-1:0] next_pc,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [CW-1:0]     occ;
  logic [CW:0]       credit;
  logic              pop;
  logic              issue;
  logic              push;

  cpu_pkg::fetch_entry_t push_entry;
  cpu_pkg::fetch_entry_t head;

  assign inst_valid = (occ != '0);
  assign pop        = inst_valid & inst_ready;

  // Slots committed after this edge: held + returning - leaving.
  assign credit = {1'b0, occ}
                + (CW + 1)'(inflight_q)
                - (CW + 1)'(pop);
  assign issue  = !reset && !redirect
               && (credit < (CW + 1)'(DEPTH));

  always_comb begin
    pc_enable     = 1'b0;
    mem_en        = 1'b0;
    next_pc       = pc;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (reset) begin
      next_pc = '0;
    end else if (redirect) begin
      pc_enable = 1'b1;
      next_pc   = redirect_pc;
    end else if (issue) begin
      pc_enable     = 1'b1;
      mem_en        = 1'b1;
      next_pc       = pc + ADDR_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign mem_addr        = pc;
  assign push            = inflight_q & !redirect;
  assign push_entry.inst = mem_rdata;
  assign push_entry.pc   = inflight_pc_q;

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop & !redirect),
    .head      (head),
    .count     (occ)
  );

  assign inst_data = head.inst;
  assign inst_pc   = head.pc;

endmodule
